// File: rtl/archel_run_ctrl.sv
// Run/step sequencer: debounced PAUSE/STEP drive free-run or burst generation requests to the core.
// Latency: input change to debounced level DEB_CYCLES+2 edges; WAIT entry to GEN_REQ (RATE+1)<<PRE_SHIFT cycles.
// Backpressure: GEN_REQ holds until GEN_DONE; the run timer is frozen while a request is outstanding.

module archel_run_ctrl_deb #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic deb
);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] LAST = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] ONE  = DW'(1);

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_nxt;
    logic          deb_nxt;

    // Count consecutive cycles of disagreement; flip when the count would reach DEB_CYCLES
    always_comb begin
        deb_nxt = deb;
        cnt_nxt = '0;
        if (sync2 != deb) begin
            if (cnt == LAST) begin
                deb_nxt = sync2;
            end else begin
                cnt_nxt = cnt + ONE;
            end
        end
    end

    // Two-flop synchroniser followed by the debounce state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            deb   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            cnt   <= cnt_nxt;
            deb   <= deb_nxt;
        end
    end
endmodule

module archel_run_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int RATE_W     = 4,
    parameter int PRE_SHIFT  = 20,
    parameter int STEP_BURST = 1,
    parameter int CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PAUSE,
    input  logic              STEP,
    input  logic [RATE_W-1:0] RATE,
    input  logic              GEN_DONE,
    output logic              GEN_REQ,
    output logic              RUNNING,
    output logic              BUSY,
    output logic [CNT_W-1:0]  GEN_COUNT
);
    localparam int TW = RATE_W + PRE_SHIFT;
    localparam int BW = $clog2(STEP_BURST + 1);
    localparam logic [TW:0]    WONE       = (TW + 1)'(1);
    localparam logic [TW-1:0]  TONE       = TW'(1);
    localparam logic [BW-1:0]  BONE       = BW'(1);
    localparam logic [BW-1:0]  BURST_INIT = BW'(STEP_BURST - 1);
    localparam logic [CNT_W-1:0] CONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_PAUSED = 2'd0,
        S_WAIT   = 2'd1,
        S_REQ    = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              pause_deb;
    logic              step_deb;
    logic              step_prev;
    logic              step_evt;
    logic              run_en;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_load;
    logic [BW-1:0]     burst_left;
    logic [CNT_W-1:0]  gen_count;

    archel_run_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
        .CLK (CLK),
        .RST (RST),
        .raw (PAUSE),
        .deb (pause_deb)
    );

    archel_run_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .CLK (CLK),
        .RST (RST),
        .raw (STEP),
        .deb (step_deb)
    );

    assign step_evt = step_deb & ~step_prev;

    // ((RATE+1)<<PRE_SHIFT)-1 split as (RATE<<PRE_SHIFT) | ((1<<PRE_SHIFT)-1): same value, never overflows TW bits
    assign timer_load = (TW'(RATE) << PRE_SHIFT) | TW'((WONE << PRE_SHIFT) - WONE);

    // Edge-detect history for STEP and the post-reset enable that lets RUNNING rise
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            step_prev <= 1'b0;
            run_en    <= 1'b0;
        end else begin
            step_prev <= step_deb;
            run_en    <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_PAUSED;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: step beats pause release, pause beats timer expiry, a request always completes
    always_comb begin
        state_nxt = state;
        case (state)
            S_PAUSED: begin
                if (step_evt) begin
                    state_nxt = S_REQ;
                end else if (!pause_deb) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pause_deb) begin
                    state_nxt = S_PAUSED;
                end else if (timer == '0) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (GEN_DONE) begin
                    if (burst_left != '0) begin
                        state_nxt = S_GAP;
                    end else if (pause_deb) begin
                        state_nxt = S_PAUSED;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_GAP:   state_nxt = S_REQ;
            default: state_nxt = S_PAUSED;
        endcase
    end

    // Run timer, burst counter and completed-generation counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer      <= '0;
            burst_left <= '0;
            gen_count  <= '0;
        end else begin
            if (state_nxt == S_WAIT && state != S_WAIT) begin
                timer <= timer_load;
            end else if (state == S_WAIT && state_nxt == S_WAIT) begin
                timer <= timer - TONE;
            end

            if (state == S_PAUSED && step_evt) begin
                burst_left <= BURST_INIT;
            end else if (state == S_WAIT && state_nxt == S_REQ) begin
                burst_left <= '0;
            end else if (state == S_REQ && state_nxt == S_GAP) begin
                burst_left <= burst_left - BONE;
            end

            if (state == S_REQ && GEN_DONE) begin
                gen_count <= gen_count + CONE;
            end
        end
    end

    // Output decode straight from registers
    always_comb begin
        GEN_REQ   = (state == S_REQ);
        BUSY      = (state == S_REQ) || (state == S_GAP);
        RUNNING   = run_en & ~pause_deb;
        GEN_COUNT = gen_count;
    end
endmodule

// File: tb/tb_archel_run_ctrl.sv
// Directed bench for archel_run_ctrl: free-run timing, debounce, bursts, priorities, wrap and reset.
// Latency: expected edge counts are hand-derived for DEB_CYCLES=4, PRE_SHIFT=2, RATE=1 (period 8).
// Backpressure: GEN_DONE is held, tied, or echoed from GEN_REQ by the tick task.

module tb_archel_run_ctrl;
    logic       CLK;
    logic       RST;
    logic       PAUSE;
    logic       STEP;
    logic [3:0] RATE;
    logic       GEN_DONE;
    logic       GEN_REQ;
    logic       RUNNING;
    logic       BUSY;
    logic [3:0] GEN_COUNT;

    int   n_tests;
    int   n_fail;
    bit   echo;

    archel_run_ctrl #(
        .DEB_CYCLES (4),
        .RATE_W     (4),
        .PRE_SHIFT  (2),
        .STEP_BURST (3),
        .CNT_W      (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PAUSE     (PAUSE),
        .STEP      (STEP),
        .RATE      (RATE),
        .GEN_DONE  (GEN_DONE),
        .GEN_REQ   (GEN_REQ),
        .RUNNING   (RUNNING),
        .BUSY      (BUSY),
        .GEN_COUNT (GEN_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle; optionally answer the core handshake immediately
    task automatic tick();
        @(posedge CLK);
        #1;
        if (echo) GEN_DONE = GEN_REQ;
    endtask

    // Edges until GEN_REQ rises; -1 if the budget runs out
    task automatic wait_rise(input int budget, output int n);
        logic prev;
        prev = GEN_REQ;
        n = 0;
        while (n < budget) begin
            tick();
            n++;
            if (GEN_REQ && !prev) return;
            prev = GEN_REQ;
        end
        n = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          cnt;
        int          run_min;
        int          run_up;
        int          run_dn;
        logic        prev;
        logic [63:0] reqv;
        logic [63:0] busyv;

        n_tests = 0;
        n_fail  = 0;
        echo    = 1'b0;
        RST = 1'b1; PAUSE = 1'b0; STEP = 1'b0; RATE = 4'd1; GEN_DONE = 1'b1;

        // Reset values
        repeat (3) tick();
        chk("rst_req", GEN_REQ, 0);
        chk("rst_running", RUNNING, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_count", GEN_COUNT, 0);

        // Free run with GEN_DONE tied high
        RST = 1'b0;
        tick();
        chk("running_after_rst", RUNNING, 1);
        chk("busy_in_wait", BUSY, 0);
        wait_rise(50, n);
        chk("first_req_delay", n, 8);
        chk("busy_in_req", BUSY, 1);
        wait_rise(50, n);
        chk("req_spacing_1", n, 9);
        wait_rise(50, n);
        chk("req_spacing_2", n, 9);
        tick();
        chk("count_after_3", GEN_COUNT, 3);

        // Short PAUSE glitch is rejected, then the next request is held without GEN_DONE
        GEN_DONE = 1'b0;
        run_min = 1;
        PAUSE = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) PAUSE = 1'b0;
            if (!RUNNING) run_min = 0;
        end
        chk("glitch_running", run_min, 1);
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (GEN_REQ) cnt++;
        end
        chk("hold_req_cycles", cnt, 50);
        chk("hold_count", GEN_COUNT, 3);

        // Held PAUSE: RUNNING falls after 6 edges, outstanding request survives
        PAUSE = 1'b1;
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (!RUNNING) begin
                n = k;
                break;
            end
        end
        chk("pause_running_delay", n, 6);
        chk("pause_keeps_req", GEN_REQ, 1);
        GEN_DONE = 1'b1;
        tick();
        GEN_DONE = 1'b0;
        chk("pause_req_done", GEN_REQ, 0);
        chk("count_after_hold", GEN_COUNT, 4);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (GEN_REQ || BUSY) cnt++;
        end
        chk("paused_idle", cnt, 0);

        // Single STEP press: burst of 3 separated by GAP
        echo = 1'b1;
        STEP = 1'b1;
        reqv = '0;
        busyv = '0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            reqv[k-1]  = GEN_REQ;
            busyv[k-1] = BUSY;
            if (k == 10) STEP = 1'b0;
        end
        chk("burst_req_pattern", reqv, 64'h540);
        chk("burst_busy_pattern", busyv, 64'h7C0);
        chk("count_after_burst", GEN_COUNT, 7);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (GEN_REQ) cnt++;
        end
        chk("burst_then_paused", cnt, 0);

        // Second STEP press during a stalled burst is dropped
        echo = 1'b0;
        GEN_DONE = 1'b0;
        STEP = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (GEN_REQ) cnt++;
            if (k == 8)  STEP = 1'b0;
            if (k == 16) STEP = 1'b1;
            if (k == 24) STEP = 1'b0;
        end
        chk("stalled_req_cycles", cnt, 34);
        chk("stalled_count", GEN_COUNT, 7);
        echo = 1'b1;
        cnt = 0;
        prev = GEN_REQ;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (GEN_REQ && !prev) cnt++;
            prev = GEN_REQ;
        end
        chk("second_press_dropped", cnt, 2);
        chk("count_after_burst2", GEN_COUNT, 10);

        // STEP event with pause release on the same edge, then pause on the timer-expiry edge
        STEP = 1'b1;
        PAUSE = 1'b0;
        reqv = '0;
        run_up = -1;
        run_dn = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            reqv[k-1] = GEN_REQ;
            if (RUNNING && run_up < 0) run_up = k;
            if (!RUNNING && k > 22 && run_dn < 0) run_dn = k;
            if (k == 10) STEP = 1'b0;
            if (k == 22) PAUSE = 1'b1;
        end
        chk("simul_req_pattern", reqv, 64'h80540);
        chk("simul_running_up", run_up, 6);
        chk("simul_running_dn", run_dn, 28);
        chk("count_after_simul", GEN_COUNT, 14);

        // Counter wrap: 17 generations total gives 1
        PAUSE = 1'b0;
        wait_rise(60, n);
        chk("resume_req_delay", n, 15);
        wait_rise(60, n);
        chk("resume_spacing_1", n, 9);
        wait_rise(60, n);
        chk("resume_spacing_2", n, 9);
        tick();
        chk("count_wrap", GEN_COUNT, 1);

        // Reset while a request is outstanding
        echo = 1'b0;
        GEN_DONE = 1'b0;
        wait_rise(30, n);
        chk("req_before_rst", n, 8);
        #4;
        RST = 1'b1;
        #1;
        chk("async_rst_req", GEN_REQ, 0);
        chk("async_rst_busy", BUSY, 0);
        chk("async_rst_running", RUNNING, 0);
        chk("async_rst_count", GEN_COUNT, 0);
        tick();
        RST = 1'b0;
        tick();
        chk("running_after_rst2", RUNNING, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/archel_run_ctrl.md
# archel_run_ctrl

Parametrised run/step sequencer for the archel generation engine, placed between the board PAUSE/STEP inputs and the core's generation-advance handshake. It synchronises and debounces both inputs, free-runs generations at a programmable rate when unpaused, and issues bursts of single-step generations when paused. Each generation is a request/done handshake with the core, and completed generations are counted.

## Interface
- DEB_CYCLES, 500000: consecutive stable cycles required to accept an input change (≥1)
- RATE_W, 4: width of RATE input
- PRE_SHIFT, 20: run period = (RATE+1) << PRE_SHIFT cycles
- STEP_BURST, 1: generations issued per STEP press (≥1)
- CNT_W, 16: width of GEN_COUNT
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- PAUSE  in  1  raw level switch, 1 = paused
- STEP  in  1  raw push button, active high
- RATE  in  RATE_W  run-speed select, sampled at timer reload
- GEN_DONE  in  1  core completed requested generation
- GEN_REQ  out  1  request core to compute next generation
- RUNNING  out  1  debounced PAUSE is 0
- BUSY  out  1  state is REQ or GAP
- GEN_COUNT  out  CNT_W  completed generations, wraps modulo 2^CNT_W

## Operation
- Input path per input: 2-flop synchroniser -> debouncer (counter increments while synced != debounced, clears when equal; debounced flips on the edge where the counter would reach DEB_CYCLES) -> registered previous value for edge detect. All reset to 0.
- STEP event = debounced STEP rising (0->1) for one cycle. Falling edges ignored.
- States: PAUSED, WAIT, REQ, GAP. Reset state PAUSED.
- PAUSED: GEN_REQ=0. STEP event -> REQ, burst_left = STEP_BURST-1 (priority over pause release). Else debounced PAUSE=0 -> WAIT, timer loaded.
- WAIT: timer decrements each cycle; at timer==0 -> REQ, burst_left=0. Debounced PAUSE=1 -> PAUSED, timer discarded (pause wins over simultaneous expiry). STEP events ignored.
- REQ: GEN_REQ=1 until GEN_DONE sampled 1. On GEN_DONE: GEN_COUNT+1; if burst_left>0 -> GAP, burst_left-1; else debounced PAUSE=1 -> PAUSED, else -> WAIT (timer reloaded). Pause change never aborts an outstanding request or burst.
- GAP: one cycle, GEN_REQ=0, -> REQ. Guarantees GEN_REQ drops between burst generations.
- GEN_DONE outside REQ ignored. STEP events outside PAUSED dropped, not queued.
- Timer width RATE_W+PRE_SHIFT; load value ((RATE+1)<<PRE_SHIFT)-1, computed at that width plus one bit, no overflow at RATE all-ones. RATE changes take effect at next load only.
- Reset outputs: GEN_REQ=0, RUNNING=0, BUSY=0, GEN_COUNT=0; counters, timer, burst_left=0. Since debounced PAUSE resets to 0, block enters WAIT one cycle after RST release with PAUSE pin low. RST mid-burst abandons the burst immediately; GEN_REQ falls asynchronously.

## Timing
- All outputs registered; GEN_REQ and BUSY decode from state register.
- RUNNING = debounced PAUSE inverted, so it is 0 during reset and rises one edge after RST release when debounced PAUSE is 0.
- Raw input change (held stable) to debounced change: DEB_CYCLES+2 edges.
- STEP raw rise (held) to GEN_REQ high while PAUSED: DEB_CYCLES+3 edges.
- WAIT entry to GEN_REQ high: (RATE+1)<<PRE_SHIFT cycles.
- GEN_DONE accepted in first GEN_REQ cycle is legal; minimum REQ duration 1 cycle.
- Free-run request spacing with GEN_DONE asserted in the first REQ cycle = P+1 cycles, P = run period.
- Burst with immediate GEN_DONE: GEN_REQ pattern 1,0,1,0,... STEP_BURST highs.
- GEN_COUNT updates the edge after GEN_DONE is accepted.

## Test plan
- Reset/free-run: DEB_CYCLES=4, PRE_SHIFT=2, RATE=1, PAUSE=0, GEN_DONE tied 1 -> state WAIT one cycle after RST release, GEN_REQ high 8 cycles after WAIT entry, then every 9 cycles; GEN_COUNT=3 after third request.
- Debounce: PAUSE glitch high for 3 cycles -> no state change; held 4+ cycles -> RUNNING low 6 edges after the pin rise, state PAUSED after current request completes.
- Single step: paused, STEP_BURST=3, STEP pulse 10 cycles, GEN_DONE one cycle after each GEN_REQ rise -> exactly 3 GEN_REQ pulses separated by GAP, GEN_COUNT +3, return to PAUSED; second STEP press during burst ignored.
- Handshake hold: GEN_DONE withheld 50 cycles -> GEN_REQ stays high 50 cycles, timer frozen, GEN_COUNT unchanged until GEN_DONE.
- Simultaneous: STEP event same cycle as pause release -> burst taken first, then WAIT; pause asserted same cycle as timer expiry -> PAUSED, no request.
- Wrap and reset: CNT_W=4, 17 generations -> GEN_COUNT=1; assert RST while GEN_REQ high -> GEN_REQ falls immediately, all outputs 0.
